// File: rtl/heap_pkg.sv
// heap_pkg: shared op encodings, FSM state type and pool defaults for the heap array allocator
package heap_pkg;
  localparam int MEM_W = 12;
  localparam int N_ARRAYS = 4;
  localparam int N_REQ = 2;
  localparam logic OP_ALLOC = 1'b0;
  localparam logic OP_FREE = 1'b1;
  typedef enum logic {ARB, EXEC} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
// req: request vector, ptr: priority start index, grant: one-hot winner, idx: winner index
module rr_arbiter #(
  parameter int NReq = 2,
  localparam int IW = NReq > 1 ? $clog2(NReq) : 1
) (
  input  logic [NReq-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NReq-1:0] grant,
  output logic [IW-1:0]   idx
);
  // Scan farthest offset first so the nearest request at or after ptr overwrites and wins.
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NReq - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NReq]) begin
        grant = '0;
        grant[(int'(ptr) + i) % NReq] = 1'b1;
        idx = IW'((int'(ptr) + i) % NReq);
      end
    end
  end
endmodule

// File: rtl/heap_array_arbiter.sv
// heap_array_arbiter: round-robin serialiser of alloc/free requests for the heap array pool
// req_*: per-requester op handshake; ack/ack_array/ack_error: completion to the served requester
// clear_valid/clear_array: zero the size-table entry of a newly allocated array
// in_use: arrays currently allocated; allocs: high-water count of fresh arrays issued
module heap_array_arbiter
  import heap_pkg::*;
#(
  parameter int MemoryElementWidth = MEM_W,
  parameter int NArrays = N_ARRAYS,
  parameter int NReq = N_REQ
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NReq-1:0]                req_valid,
  input  logic [NReq-1:0]                req_free,
  input  logic [NReq*MemoryElementWidth-1:0] req_array,
  output logic [NReq-1:0]                ack,
  output logic [MemoryElementWidth-1:0]  ack_array,
  output logic                           ack_error,
  output logic                           clear_valid,
  output logic [MemoryElementWidth-1:0]  clear_array,
  output logic [MemoryElementWidth-1:0]  in_use,
  output logic [MemoryElementWidth-1:0]  allocs
);
  localparam int W = MemoryElementWidth;
  localparam int AW = NArrays > 1 ? $clog2(NArrays) : 1;
  localparam int IW = NReq > 1 ? $clog2(NReq) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] sel_q, sel_d, rr_q, rr_d, grant_idx;
  logic [NReq-1:0] grant;
  logic op_q, op_d;
  logic [W-1:0] arr_q, arr_d, top_q, top_d, allocs_q, allocs_d, in_use_q, in_use_d, alloc_res;
  logic [W-1:0] stack_q [NArrays];
  logic [W-1:0] stack_d [NArrays];
  logic [NArrays-1:0] bitmap_q, bitmap_d;
  logic done, pop, alloc_ok, free_ok;
  rr_arbiter #(.NReq(NReq)) u_rr (
    .req  (req_valid),
    .ptr  (rr_q),
    .grant(grant),
    .idx  (grant_idx)
  );
  // Completion outputs decode the latched op; reset gates them so an abandoned op never acks.
  always_comb begin
    done = state_q == EXEC && !reset;
    pop = top_q != '0;
    alloc_res = pop ? stack_q[AW'(top_q - W'(1))] : allocs_q;
    alloc_ok = op_q == OP_ALLOC && (pop || allocs_q < W'(NArrays));
    free_ok = op_q == OP_FREE && arr_q < allocs_q && bitmap_q[AW'(arr_q)];
    ack = done ? NReq'(1) << sel_q : '0;
    ack_error = done && !(alloc_ok || free_ok);
    clear_valid = done && alloc_ok;
    clear_array = clear_valid ? alloc_res : '0;
    ack_array = !done ? '0 : op_q == OP_FREE ? arr_q : clear_array;
    in_use = in_use_q;
    allocs = allocs_q;
  end
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    op_d = op_q;
    arr_d = arr_q;
    rr_d = rr_q;
    top_d = top_q;
    allocs_d = allocs_q;
    in_use_d = in_use_q;
    stack_d = stack_q;
    bitmap_d = bitmap_q;
    if (state_q == ARB) begin
      if (|grant) begin
        state_d = EXEC;
        sel_d = grant_idx;
        op_d = req_free[grant_idx];
        arr_d = req_array[int'(grant_idx)*W +: W];
      end
    end else begin
      state_d = ARB;
      rr_d = sel_q == IW'(NReq - 1) ? '0 : sel_q + IW'(1);
      if (alloc_ok) begin
        bitmap_d[AW'(alloc_res)] = 1'b1;
        in_use_d = in_use_q + W'(1);
        top_d = pop ? top_q - W'(1) : top_q;
        allocs_d = pop ? allocs_q : allocs_q + W'(1);
      end
      if (free_ok) begin
        bitmap_d[AW'(arr_q)] = 1'b0;
        stack_d[AW'(top_q)] = arr_q;
        top_d = top_q + W'(1);
        in_use_d = in_use_q - W'(1);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB;
      sel_q <= '0;
      op_q <= OP_ALLOC;
      arr_q <= '0;
      rr_q <= '0;
      top_q <= '0;
      allocs_q <= '0;
      in_use_q <= '0;
      stack_q <= '{default: '0};
      bitmap_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      op_q <= op_d;
      arr_q <= arr_d;
      rr_q <= rr_d;
      top_q <= top_d;
      allocs_q <= allocs_d;
      in_use_q <= in_use_d;
      stack_q <= stack_d;
      bitmap_q <= bitmap_d;
    end
  end
  // Frees are bounded by in_use, so the freed stack can never exceed the pool size.
  always_ff @(posedge clock) begin
    if (!reset) assert (top_q <= W'(NArrays));
  end
endmodule

// File: tb/tb_heap_array_arbiter.sv
// tb_heap_array_arbiter: directed self-checking bench for heap_array_arbiter
module tb_heap_array_arbiter;
  localparam int W = 12;
  localparam int NR = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_free = '0;
  logic [NR*W-1:0] req_array = '0;
  logic [NR-1:0] ack;
  logic [W-1:0] ack_array, clear_array, in_use, allocs;
  logic ack_error, clear_valid;
  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [NR-1:0] g_ack;
  logic [W-1:0] g_arr, g_clra;
  logic g_err, g_clr;
  heap_array_arbiter #(.MemoryElementWidth(W), .NArrays(4), .NReq(NR)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_free   (req_free),
    .req_array  (req_array),
    .ack        (ack),
    .ack_array  (ack_array),
    .ack_error  (ack_error),
    .clear_valid(clear_valid),
    .clear_array(clear_array),
    .in_use     (in_use),
    .allocs     (allocs)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic do_op(input int r, input logic f, input logic [W-1:0] a);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    lat = 0;
    req_valid[r] = 1'b1;
    req_free[r] = f;
    req_array[r*W +: W] = a;
    while (!seen && n < 8) begin
      tick();
      n++;
      if (ack[r]) begin
        seen = 1'b1;
        lat = n;
        g_ack = ack;
        g_arr = ack_array;
        g_err = ack_error;
        g_clr = clear_valid;
        g_clra = clear_array;
      end
    end
    chk("ack_seen", 32'(seen), 1);
    req_valid[r] = 1'b0;
    tick();
    chk("pulse_low", 32'({ack, clear_valid, ack_error}), 0);
  endtask
  initial begin
    int t, k;
    int cyc[4];
    logic [NR-1:0] ak[4];
    logic [W-1:0] aa[4];
    do_reset();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_clr", 32'(clear_valid), 0);
    chk("rst_allocs", 32'(allocs), 0);
    chk("rst_in_use", 32'(in_use), 0);
    // 1: first alloc
    do_op(0, 1'b0, '0);
    chk("t1_lat", 32'(lat), 1);
    chk("t1_ack", 32'(g_ack), 1);
    chk("t1_arr", 32'(g_arr), 0);
    chk("t1_err", 32'(g_err), 0);
    chk("t1_clr", 32'(g_clr), 1);
    chk("t1_clra", 32'(g_clra), 0);
    chk("t1_allocs", 32'(allocs), 1);
    chk("t1_in_use", 32'(in_use), 1);
    // 2: exhaust the pool
    for (int i = 1; i < 4; i++) begin
      do_op(0, 1'b0, '0);
      chk("t2_arr", 32'(g_arr), 32'(i));
      chk("t2_clra", 32'(g_clra), 32'(i));
    end
    do_op(0, 1'b0, '0);
    chk("t2_full_err", 32'(g_err), 1);
    chk("t2_full_arr", 32'(g_arr), 0);
    chk("t2_full_clr", 32'(g_clr), 0);
    chk("t2_allocs", 32'(allocs), 4);
    chk("t2_in_use", 32'(in_use), 4);
    // 3: LIFO reuse
    do_reset();
    for (int i = 0; i < 3; i++) do_op(0, 1'b0, '0);
    do_op(0, 1'b1, 12'd1);
    chk("t3_free1_err", 32'(g_err), 0);
    chk("t3_free1_echo", 32'(g_arr), 1);
    chk("t3_free1_clr", 32'(g_clr), 0);
    do_op(1, 1'b1, 12'd2);
    chk("t3_free2_err", 32'(g_err), 0);
    chk("t3_in_use_mid", 32'(in_use), 1);
    do_op(0, 1'b0, '0);
    chk("t3_lifo_a", 32'(g_arr), 2);
    chk("t3_lifo_clra", 32'(g_clra), 2);
    do_op(0, 1'b0, '0);
    chk("t3_lifo_b", 32'(g_arr), 1);
    chk("t3_allocs", 32'(allocs), 3);
    chk("t3_in_use", 32'(in_use), 3);
    // 4: error frees leave state untouched
    do_reset();
    do_op(0, 1'b0, '0);
    do_op(0, 1'b0, '0);
    do_op(0, 1'b1, 12'd3);
    chk("t4_oor_err", 32'(g_err), 1);
    chk("t4_oor_echo", 32'(g_arr), 3);
    chk("t4_oor_in_use", 32'(in_use), 2);
    do_op(1, 1'b1, 12'd1);
    chk("t4_free_err", 32'(g_err), 0);
    chk("t4_free_in_use", 32'(in_use), 1);
    do_op(1, 1'b1, 12'd1);
    chk("t4_dbl_err", 32'(g_err), 1);
    chk("t4_dbl_echo", 32'(g_arr), 1);
    chk("t4_dbl_in_use", 32'(in_use), 1);
    do_op(0, 1'b0, '0);
    chk("t4_realloc", 32'(g_arr), 1);
    chk("t4_allocs", 32'(allocs), 2);
    chk("t4_in_use", 32'(in_use), 2);
    // 5: two requesters holding alloc alternate
    do_reset();
    req_free = '0;
    req_valid = 2'b11;
    t = 0;
    k = 0;
    while (k < 4 && t < 20) begin
      tick();
      t++;
      if (ack != '0) begin
        ak[k] = ack;
        aa[k] = ack_array;
        cyc[k] = t;
        k++;
      end
    end
    req_valid = '0;
    tick();
    tick();
    chk("t5_count", 32'(k), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_ack", 32'(k > i ? ak[i] : '0), (i % 2 == 0) ? 1 : 2);
      chk("t5_arr", 32'(k > i ? aa[i] : '0), 32'(i));
    end
    for (int i = 1; i < 4; i++) chk("t5_gap", 32'(k > i ? cyc[i] - cyc[i-1] : 0), 2);
    chk("t5_allocs", 32'(allocs), 4);
    // 6: reset during EXEC abandons the op
    do_reset();
    req_free = '0;
    req_valid[0] = 1'b1;
    tick();
    chk("t6_exec_ack", 32'(ack), 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_ack", 32'(ack), 0);
    chk("t6_rst_clr", 32'(clear_valid), 0);
    req_valid = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_allocs", 32'(allocs), 0);
    chk("t6_in_use", 32'(in_use), 0);
    do_op(0, 1'b0, '0);
    chk("t6_next_arr", 32'(g_arr), 0);
    chk("t6_next_err", 32'(g_err), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
